// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_cmd_pkg
// Brief   : Shared opcodes, response codes and FSM states for uart_cmd_ctrl.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_WRITE = 4'h1,
    OP_READ  = 4'h2
  } opcode_t;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    SEND    = 2'd2,
    WAIT_TX = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cfg_regbank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : cfg_regbank
// Brief   : NREGS x 8-bit config registers, single address, async read.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module cfg_regbank #(
  parameter int NREGS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_we,
  input  logic [3:0]         i_addr,
  input  logic [7:0]         i_wdata,
  output logic [7:0]         o_rdata,
  output logic [NREGS*8-1:0] o_cfg_q
);

  genvar g;
  generate
    for (g = 0; g < NREGS; g++) begin : g_reg
      logic [7:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (i_we && (i_addr == 4'(g))) begin
          r_q <= i_wdata;
        end
      end
      assign o_cfg_q[8*g +: 8] = r_q;
    end
  endgenerate

  // Out-of-range addresses read as zero; the sequencer NAKs them anyway.
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (i_addr == 4'(i)) o_rdata = o_cfg_q[8*i +: 8];
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_cmd_ctrl
// Brief   : UART command sequencer: decode/execute against the config bank,
//           one response byte per command, arbitrated with status events.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         NREGS      = 8,
  parameter int         TX_TIMEOUT = 65535,
  parameter logic [7:0] EVT_CODE   = 8'hC3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cmd_rdy,
  input  logic [15:0]        i_cmd,
  output logic               o_clr_cmd_rdy,
  output logic               o_send_resp,
  output logic [7:0]         o_resp,
  input  logic               i_resp_sent,
  input  logic               i_evt_req,
  output logic [NREGS*8-1:0] o_cfg_q,
  output logic               o_busy,
  output logic               o_tx_err
);

  localparam int             TW      = $clog2(TX_TIMEOUT + 1);
  localparam logic [TW-1:0]  C_TMAX  = TW'(TX_TIMEOUT - 1);
  localparam logic [4:0]     C_NREGS = 5'(NREGS);

  state_t        r_state, w_next;
  logic [15:0]   r_cmd_q;
  logic          r_evt_pend;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_resp;
  logic          r_tx_err;

  logic          w_latch, w_evt_clr, w_we, w_timeout, w_resp_ld, w_addr_ok;
  logic [7:0]    w_resp_nxt, w_rdata;

  cfg_regbank #(.NREGS(NREGS)) u_regbank (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_addr  (r_cmd_q[11:8]),
    .i_wdata (r_cmd_q[7:0]),
    .o_rdata (w_rdata),
    .o_cfg_q (o_cfg_q)
  );

  assign w_addr_ok = ({1'b0, r_cmd_q[11:8]} < C_NREGS);

  always_comb begin
    w_next        = r_state;
    o_clr_cmd_rdy = 1'b0;
    o_send_resp   = 1'b0;
    w_latch       = 1'b0;
    w_evt_clr     = 1'b0;
    w_we          = 1'b0;
    w_timeout     = 1'b0;
    w_resp_ld     = 1'b0;
    w_resp_nxt    = r_resp;
    case (r_state)
      IDLE: begin
        // A waiting command always beats a pending event.
        if (i_cmd_rdy) begin
          o_clr_cmd_rdy = 1'b1;
          w_latch       = 1'b1;
          w_next        = EXEC;
        end else if (r_evt_pend) begin
          w_evt_clr  = 1'b1;
          w_resp_ld  = 1'b1;
          w_resp_nxt = EVT_CODE;
          w_next     = SEND;
        end
      end
      EXEC: begin
        w_resp_ld = 1'b1;
        case (r_cmd_q[15:12])
          OP_NOP:   w_resp_nxt = ACK;
          OP_WRITE: begin
            w_we       = w_addr_ok;
            w_resp_nxt = w_addr_ok ? ACK : NAK;
          end
          OP_READ:  w_resp_nxt = w_addr_ok ? w_rdata : NAK;
          default:  w_resp_nxt = NAK;
        endcase
        w_next = SEND;
      end
      SEND: begin
        o_send_resp = 1'b1;
        w_next      = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_resp_sent) begin
          w_next = IDLE;
        end else if (r_timer == C_TMAX) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cmd_q    <= '0;
      r_evt_pend <= 1'b0;
      r_timer    <= '0;
      r_resp     <= '0;
      r_tx_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch)   r_cmd_q <= i_cmd;
      if (w_resp_ld) r_resp  <= w_resp_nxt;
      if (w_timeout) r_tx_err <= 1'b1;
      // A new request in the service cycle must survive the clear.
      if (i_evt_req)      r_evt_pend <= 1'b1;
      else if (w_evt_clr) r_evt_pend <= 1'b0;
      if (r_state != WAIT_TX)  r_timer <= '0;
      else if (r_timer != '1)  r_timer <= r_timer + 1'b1;
    end
  end

  assign o_resp   = r_resp;
  assign o_busy   = (r_state != IDLE);
  assign o_tx_err = r_tx_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_uart_cmd_ctrl
// Brief   : Self-checking bench for uart_cmd_ctrl against a transaction model.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  localparam int         NR  = 8;
  localparam int         TMO = 16;
  localparam logic [7:0] EVT = 8'hC3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_cmd_rdy = 1'b0;
  logic [15:0]   i_cmd = '0;
  logic          o_clr_cmd_rdy, o_send_resp, o_busy, o_tx_err;
  logic [7:0]    o_resp;
  logic          i_resp_sent = 1'b0;
  logic          i_evt_req = 1'b0;
  logic [NR*8-1:0] o_cfg_q;

  uart_cmd_ctrl #(.NREGS(NR), .TX_TIMEOUT(TMO), .EVT_CODE(EVT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_rdy     (i_cmd_rdy),
    .i_cmd         (i_cmd),
    .o_clr_cmd_rdy (o_clr_cmd_rdy),
    .o_send_resp   (o_send_resp),
    .o_resp        (o_resp),
    .i_resp_sent   (i_resp_sent),
    .i_evt_req     (i_evt_req),
    .o_cfg_q       (o_cfg_q),
    .o_busy        (o_busy),
    .o_tx_err      (o_tx_err)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_regs [NR];
  logic       m_txerr = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model: command semantics applied to an array of registers.
  function automatic logic [7:0] model_cmd(input logic [15:0] c);
    int a;
    a = int'(c[11:8]);
    case (c[15:12])
      4'h0: return 8'hA5;
      4'h1: begin
        if (a < NR) begin
          m_regs[a] = c[7:0];
          return 8'hA5;
        end
        return 8'hEE;
      end
      4'h2: begin
        if (a < NR) return m_regs[a];
        return 8'hEE;
      end
      default: return 8'hEE;
    endcase
  endfunction

  function automatic logic [63:0] m_cfg();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NR; i++) r[8*i +: 8] = m_regs[i];
    return r;
  endfunction

  // Present a command and follow it to the first WAIT_TX cycle.
  task automatic issue_cmd(input logic [15:0] c, output logic [7:0] e);
    int n;
    e = model_cmd(c);
    i_cmd = c;
    i_cmd_rdy = 1'b1;
    #1;
    n = 0;
    while (!o_clr_cmd_rdy && n < 64) begin
      step();
      n++;
    end
    check("clr_cmd_rdy", 64'(o_clr_cmd_rdy), 64'(1));
    step();
    i_cmd_rdy = 1'b0;
    i_cmd = 16'($urandom);
    check("exec_busy", 64'(o_busy), 64'(1));
    check("exec_no_send", 64'(o_send_resp), 64'(0));
    step();
    check("send_latency", 64'(o_send_resp), 64'(1));
    check("resp", 64'(o_resp), 64'(e));
    check("cfg_q", 64'(o_cfg_q), m_cfg());
    step();
    check("send_width", 64'(o_send_resp), 64'(0));
  endtask

  // Hold in WAIT_TX for dly cycles, resp_sent on the last; optional events
  // and an optional next command presented together with resp_sent.
  task automatic tx_wait(input int dly, input logic [7:0] e, input int nevt, input logic [16:0] nxt);
    for (int k = 1; k <= dly; k++) begin
      check("resp_hold", 64'(o_resp), 64'(e));
      i_resp_sent = (k == dly);
      i_evt_req   = ((k % 2) == 1) && (k <= 2 * nevt);
      if (k == dly && nxt[16]) begin
        i_cmd     = nxt[15:0];
        i_cmd_rdy = 1'b1;
      end
      step();
    end
    i_resp_sent = 1'b0;
    i_evt_req   = 1'b0;
    check("back_idle", 64'(o_busy), 64'(0));
    check("tx_err", 64'(o_tx_err), 64'(m_txerr));
  endtask

  task automatic expect_evt(input logic extra, input int dly);
    check("evt_from_idle", 64'(o_busy), 64'(0));
    i_evt_req = extra;
    step();
    i_evt_req = 1'b0;
    check("evt_send", 64'(o_send_resp), 64'(1));
    check("evt_resp", 64'(o_resp), 64'(EVT));
    step();
    check("evt_send_width", 64'(o_send_resp), 64'(0));
    tx_wait(dly, EVT, 0, '0);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("quiet_send", 64'(o_send_resp), 64'(0));
      check("quiet_busy", 64'(o_busy), 64'(0));
    end
  endtask

  task automatic check_reset_vals();
    check("rst_clr", 64'(o_clr_cmd_rdy), 64'(0));
    check("rst_send", 64'(o_send_resp), 64'(0));
    check("rst_resp", 64'(o_resp), 64'(0));
    check("rst_cfg", 64'(o_cfg_q), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_txerr", 64'(o_tx_err), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  e;
    logic [15:0] c;
    int          dly, nevt, r;
    logic        extra;

    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals();
    rst_n = 1'b1;
    step();

    // Write then read back the same register.
    issue_cmd(16'h1342, e);
    tx_wait(2, e, 0, '0);
    issue_cmd(16'h2300, e);
    check("read_0x42", 64'(o_resp), 64'(8'h42));
    check("cfg_reg3", 64'(o_cfg_q[31:24]), 64'(8'h42));
    tx_wait(1, e, 0, '0);

    // Illegal opcode and out-of-range write.
    issue_cmd(16'h7000, e);
    tx_wait(3, e, 0, '0);
    issue_cmd(16'h1F11, e);
    tx_wait(2, e, 0, '0);

    // Coalesced events, then one re-requested in the service cycle.
    issue_cmd(16'h0000, e);
    tx_wait(8, e, 3, '0);
    expect_evt(1'b1, 2);
    expect_evt(1'b0, 2);
    quiet(3);

    // Command and pending event together: command first.
    issue_cmd(16'h2300, e);
    tx_wait(4, e, 1, {1'b1, 16'h2000});
    issue_cmd(16'h2000, e);
    tx_wait(3, e, 0, '0);
    expect_evt(1'b0, 3);
    quiet(2);

    for (int t = 0; t < 40; t++) begin
      c = 16'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 4)       c[15:12] = 4'h1;
      else if (r < 7)  c[15:12] = 4'h2;
      else if (r == 7) c[15:12] = 4'h0;
      else             c[15:12] = 4'($urandom_range(3, 15));
      c[11:8] = 4'($urandom_range(0, 11));
      dly  = int'($urandom_range(1, TMO));
      nevt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (dly < 2 * nevt) dly = 2 * nevt;
      issue_cmd(c, e);
      tx_wait(dly, e, nevt, '0);
      if (nevt > 0) begin
        extra = ($urandom_range(0, 3) == 0);
        expect_evt(extra, int'($urandom_range(1, TMO)));
        if (extra) expect_evt(1'b0, int'($urandom_range(1, TMO)));
      end
      quiet(1);
    end

    // resp_sent exactly on the last allowed cycle is a success.
    issue_cmd(16'h0000, e);
    tx_wait(TMO, e, 0, '0);

    // Timeout without resp_sent.
    issue_cmd(16'h0000, e);
    for (int k = 1; k <= TMO; k++) begin
      check("to_busy", 64'(o_busy), 64'(1));
      check("to_err_pre", 64'(o_tx_err), 64'(0));
      step();
    end
    check("to_idle", 64'(o_busy), 64'(0));
    check("tx_err_set", 64'(o_tx_err), 64'(1));
    m_txerr = 1'b1;
    issue_cmd(16'h2100, e);
    tx_wait(3, e, 0, '0);

    // Asynchronous reset in WAIT_TX after a write.
    issue_cmd(16'h10FF, e);
    step();
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_txerr = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    issue_cmd(16'h1511, e);
    tx_wait(2, e, 0, '0);
    issue_cmd(16'h2500, e);
    check("post_rst_read", 64'(o_resp), 64'(8'h11));
    tx_wait(2, e, 0, '0);
    issue_cmd(16'h2000, e);
    tx_wait(1, e, 0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
